// File: rtl/bp_update_queue_if.sv
// Fetch/resolve/PHT-port bundle for the branch prediction update queue.
// The queue drives the PHT ports through the slave modport.
interface bp_update_queue_if #(
    parameter int ROW_IDX_WIDTH = 6,
    parameter int COL_IDX_WIDTH = 3,
    parameter int DEPTH         = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                     fetch_valid;
    logic [ROW_IDX_WIDTH-1:0] fetch_row_idx;
    logic                     pht_br_taken;
    logic                     push_ready;
    logic [ROW_IDX_WIDTH-1:0] read_row_idx;
    logic [COL_IDX_WIDTH-1:0] read_col_idx;
    logic                     resolve_valid;
    logic                     resolve_taken;
    logic                     load_pht;
    logic                     br_en_out;
    logic [ROW_IDX_WIDTH-1:0] write_row_idx;
    logic [COL_IDX_WIDTH-1:0] write_col_idx;
    logic                     mispredict;
    logic [CNT_W-1:0]         count;

    modport master (
        output fetch_valid, fetch_row_idx, pht_br_taken, resolve_valid, resolve_taken,
        input  push_ready, read_row_idx, read_col_idx, load_pht, br_en_out,
               write_row_idx, write_col_idx, mispredict, count
    );

    modport slave (
        input  fetch_valid, fetch_row_idx, pht_br_taken, resolve_valid, resolve_taken,
        output push_ready, read_row_idx, read_col_idx, load_pht, br_en_out,
               write_row_idx, write_col_idx, mispredict, count
    );
endinterface

// File: rtl/bp_update_queue.sv
// In-order queue of in-flight branch predictions: forms the PHT read index from a
// speculative GHR, retires resolved branches into PHT writes and repairs the GHR on mispredict.
module bp_update_queue #(
    parameter int ROW_IDX_WIDTH = 6,
    parameter int COL_IDX_WIDTH = 3,
    parameter int DEPTH         = 4
) (
    input  logic              clk,
    input  logic              rst,
    bp_update_queue_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [COL_IDX_WIDTH-1:0] ghr_shift(
        input logic [COL_IDX_WIDTH-1:0] ghr,
        input logic                     outcome
    );
        return {ghr[COL_IDX_WIDTH-2:0], outcome};
    endfunction

    logic [ROW_IDX_WIDTH-1:0] row_mem  [DEPTH];
    logic [COL_IDX_WIDTH-1:0] col_mem  [DEPTH];
    logic                     pred_mem [DEPTH];

    logic [PTR_W-1:0]         head_q;
    logic [PTR_W-1:0]         tail_q;
    logic [CNT_W-1:0]         count_q;
    logic [COL_IDX_WIDTH-1:0] spec_ghr_q;
    logic [COL_IDX_WIDTH-1:0] commit_ghr_q;

    logic                     vld_p1;
    logic                     br_en_p1;
    logic [ROW_IDX_WIDTH-1:0] write_row_p1;
    logic [COL_IDX_WIDTH-1:0] write_col_p1;
    logic                     mispredict_p1;

    logic                     push_ready_p0;
    logic                     push_p0;
    logic                     pop_p0;
    logic                     mispredict_p0;
    logic [COL_IDX_WIDTH-1:0] commit_ghr_next_p0;

    // ---- stage p0: handshake decisions from current queue state ----
    always_comb begin
        push_ready_p0      = (count_q != CNT_W'(DEPTH));
        push_p0            = bus.fetch_valid & push_ready_p0;
        pop_p0             = bus.resolve_valid & (count_q != '0);
        mispredict_p0      = pop_p0 & (pred_mem[head_q] != bus.resolve_taken);
        commit_ghr_next_p0 = ghr_shift(commit_ghr_q, bus.resolve_taken);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            spec_ghr_q   <= '0;
            commit_ghr_q <= '0;
        end else begin
            if (pop_p0)
                commit_ghr_q <= commit_ghr_next_p0;
            if (mispredict_p0) begin
                // Flush everything younger; a same-cycle push is on the wrong path.
                head_q     <= head_q + PTR_W'(1);
                tail_q     <= head_q + PTR_W'(1);
                count_q    <= '0;
                spec_ghr_q <= commit_ghr_next_p0;
            end else begin
                if (push_p0) begin
                    tail_q     <= tail_q + PTR_W'(1);
                    spec_ghr_q <= ghr_shift(spec_ghr_q, bus.pht_br_taken);
                end
                if (pop_p0)
                    head_q <= head_q + PTR_W'(1);
                count_q <= count_q + CNT_W'(push_p0) - CNT_W'(pop_p0);
            end
        end
    end

    // Entry storage carries no reset; validity is tracked by head/tail/count alone.
    always_ff @(posedge clk) begin
        if (push_p0 && !mispredict_p0) begin
            row_mem[tail_q]  <= bus.fetch_row_idx;
            col_mem[tail_q]  <= spec_ghr_q;
            pred_mem[tail_q] <= bus.pht_br_taken;
        end
    end

    // ---- stage p1: registered PHT write port, one write per popped entry ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1        <= 1'b0;
            mispredict_p1 <= 1'b0;
            br_en_p1      <= 1'b0;
            write_row_p1  <= '0;
            write_col_p1  <= '0;
        end else begin
            vld_p1        <= pop_p0;
            mispredict_p1 <= mispredict_p0;
            if (pop_p0) begin
                br_en_p1     <= bus.resolve_taken;
                write_row_p1 <= row_mem[head_q];
                write_col_p1 <= col_mem[head_q];
            end
        end
    end

    assign bus.push_ready    = push_ready_p0;
    assign bus.read_row_idx  = bus.fetch_row_idx;
    assign bus.read_col_idx  = spec_ghr_q;
    assign bus.load_pht      = vld_p1;
    assign bus.br_en_out     = br_en_p1;
    assign bus.write_row_idx = write_row_p1;
    assign bus.write_col_idx = write_col_p1;
    assign bus.mispredict    = mispredict_p1;
    assign bus.count         = count_q;
endmodule

// File: tb/tb_bp_update_queue.sv
// Directed vector bench for bp_update_queue (COL_IDX_WIDTH=3, DEPTH=4).
module tb_bp_update_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    bp_update_queue_if #(.ROW_IDX_WIDTH(6), .COL_IDX_WIDTH(3), .DEPTH(4)) bus ();

    bp_update_queue #(.ROW_IDX_WIDTH(6), .COL_IDX_WIDTH(3), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       fv;
        logic [5:0] row;
        logic       pt;
        logic       rv;
        logic       rt;
        int         e_count;
        logic       e_load;
        logic       e_br;
        logic [5:0] e_wr;
        logic [2:0] e_wc;
        logic       e_mis;
        logic       e_pr;
        logic [2:0] e_rc;
    } vec_t;

    typedef struct {
        logic [5:0] row;
        logic [2:0] col;
        logic       pred;
    } ent_t;

    vec_t vt [12];
    ent_t q[$];
    logic [2:0] ghr;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [5:0] row, input logic pt,
                         input logic rv, input logic rt);
        bus.fetch_valid   = fv;
        bus.fetch_row_idx = row;
        bus.pht_br_taken  = pt;
        bus.resolve_valid = rv;
        bus.resolve_taken = rt;
    endtask

    task automatic step(input logic fv, input logic [5:0] row, input logic pt,
                        input logic rv, input logic rt);
        @(negedge clk);
        drive(fv, row, pt, rv, rt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            fv row pt rv rt  cnt ld br wr wc mis pr rc
        vt[0]  = '{1'b1, 6'd5,  1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 3'b001};
        vt[1]  = '{1'b1, 6'd6,  1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 3'b010};
        vt[2]  = '{1'b1, 6'd7,  1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 3'b101};
        vt[3]  = '{1'b1, 6'd8,  1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 3'b011};
        vt[4]  = '{1'b1, 6'd9,  1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 3'b011};
        vt[5]  = '{1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 3, 1'b1, 1'b1, 6'd5, 3'd0, 1'b0, 1'b1, 3'b011};
        vt[6]  = '{1'b1, 6'd9,  1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b0, 6'd6, 3'd1, 1'b0, 1'b1, 3'b110};
        vt[7]  = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 6'd6, 3'd1, 1'b0, 1'b1, 3'b110};
        vt[8]  = '{1'b1, 6'd11, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 6'd7, 3'd2, 1'b1, 1'b1, 3'b100};
        vt[9]  = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 6'd7, 3'd2, 1'b0, 1'b1, 3'b100};
        vt[10] = '{1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 6'd7, 3'd2, 1'b0, 1'b1, 3'b100};
        vt[11] = '{1'b1, 6'd12, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 6'd7, 3'd2, 1'b0, 1'b1, 3'b000};

        drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", int'(bus.count), 0);
        check("rst_load", int'(bus.load_pht), 0);
        check("rst_mis", int'(bus.mispredict), 0);
        check("rst_rcol", int'(bus.read_col_idx), 0);
        check("rst_ready", int'(bus.push_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step(vt[i].fv, vt[i].row, vt[i].pt, vt[i].rv, vt[i].rt);
            check($sformatf("v%0d_count", i), int'(bus.count), vt[i].e_count);
            check($sformatf("v%0d_load", i), int'(bus.load_pht), int'(vt[i].e_load));
            check($sformatf("v%0d_br", i), int'(bus.br_en_out), int'(vt[i].e_br));
            check($sformatf("v%0d_wrow", i), int'(bus.write_row_idx), int'(vt[i].e_wr));
            check($sformatf("v%0d_wcol", i), int'(bus.write_col_idx), int'(vt[i].e_wc));
            check($sformatf("v%0d_mis", i), int'(bus.mispredict), int'(vt[i].e_mis));
            check($sformatf("v%0d_ready", i), int'(bus.push_ready), int'(vt[i].e_pr));
            check($sformatf("v%0d_rcol", i), int'(bus.read_col_idx), int'(vt[i].e_rc));
        end
        check("rrow_passthru", int'(bus.read_row_idx), 12);

        // Pointer wrap: one entry in flight, ten same-cycle correct pop + push pairs.
        q.push_back('{6'd12, 3'b100, 1'b0});
        ghr = 3'b000;
        for (int i = 0; i < 10; i++) begin
            logic [5:0] r;
            logic       t;
            ent_t       h;
            r = 6'(20 + i);
            t = logic'((i % 3) != 1);
            h = q.pop_front();
            step(1'b1, r, t, 1'b1, h.pred);
            q.push_back('{r, ghr, t});
            ghr = {ghr[1:0], t};
            check($sformatf("w%0d_load", i), int'(bus.load_pht), 1);
            check($sformatf("w%0d_br", i), int'(bus.br_en_out), int'(h.pred));
            check($sformatf("w%0d_wrow", i), int'(bus.write_row_idx), int'(h.row));
            check($sformatf("w%0d_wcol", i), int'(bus.write_col_idx), int'(h.col));
            check($sformatf("w%0d_mis", i), int'(bus.mispredict), 0);
            check($sformatf("w%0d_count", i), int'(bus.count), 1);
            check($sformatf("w%0d_rcol", i), int'(bus.read_col_idx), int'(ghr));
        end

        // Fill to 4, pop one, then assert reset asynchronously mid-cycle.
        for (int i = 0; i < 3; i++)
            step(1'b1, 6'(40 + i), 1'b1, 1'b0, 1'b0);
        check("fill_count", int'(bus.count), 4);
        step(1'b0, 6'd0, 1'b0, 1'b1, q[0].pred);
        check("prerst_load", int'(bus.load_pht), 1);
        check("prerst_count", int'(bus.count), 3);
        #1 rst = 1'b1;
        #1;
        check("arst_count", int'(bus.count), 0);
        check("arst_load", int'(bus.load_pht), 0);
        check("arst_mis", int'(bus.mispredict), 0);
        check("arst_rcol", int'(bus.read_col_idx), 0);
        check("arst_ready", int'(bus.push_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 6'd0, 1'b0, 1'b1, 1'b1);
            check($sformatf("postrst%0d_load", i), int'(bus.load_pht), 0);
            check($sformatf("postrst%0d_count", i), int'(bus.count), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
